// File: rtl/mux_2x1_rr.sv
`default_nettype none
// ============================================================================
//  Module   : mux_2x1_rr
//  Purpose  : Recombines two demuxed 4-bit lanes into one stream. Each lane
//             has a 4-entry FIFO. A round-robin arbiter pops at most one word
//             per cycle into a registered output. A push into a full FIFO is
//             dropped and raises a sticky error flag.
//  Ports    : clk        - single clock, rising edge
//             reset_L    - asynchronous active-low reset
//             data_in0/1 - lane data, pushed when valid_in0/1 is high
//             valid_in0/1- lane push requests
//             data_out   - registered recombined word
//             valid_out  - data_out carries a new word this cycle
//             full0/1    - lane FIFO holds 4 words
//             err        - sticky overflow flag
//  Revision : 1.0  initial release
// ============================================================================
module mux_2x1_rr (
  input  logic       clk,
  input  logic       reset_L,
  input  logic [3:0] data_in0,
  input  logic       valid_in0,
  input  logic [3:0] data_in1,
  input  logic       valid_in1,
  output logic [3:0] data_out,
  output logic       valid_out,
  output logic       full0,
  output logic       full1,
  output logic       err
);

  localparam int unsigned DEPTH    = 4;
  localparam logic [2:0]  FULL_CNT = 3'd4;

  // Per-lane FIFO state, indexed by lane number.
  logic [3:0] mem_q  [2][DEPTH];
  logic [1:0] wptr_q [2];
  logic [1:0] wptr_d [2];
  logic [1:0] rptr_q [2];
  logic [1:0] rptr_d [2];
  logic [2:0] cnt_q  [2];
  logic [2:0] cnt_d  [2];

  // Lane index of the most recent pop; the other lane wins a contention.
  logic       last_grant_q, last_grant_d;
  logic [3:0] data_out_q, data_out_d;
  logic       valid_out_q, valid_out_d;
  logic       err_q, err_d;

  logic [3:0] w_din [2];
  logic [1:0] w_valid;
  logic [1:0] w_push;
  logic [1:0] w_ovf;
  logic [1:0] w_ne;
  logic [1:0] w_pop;

  // Push/pop decisions use only the registered counts, so a word pushed at
  // an edge cannot be popped at that same edge.
  always_comb begin
    w_din[0] = data_in0;
    w_din[1] = data_in1;
    w_valid  = {valid_in1, valid_in0};
    w_ne     = 2'b00;
    w_push   = 2'b00;
    w_ovf    = 2'b00;
    for (int l = 0; l < 2; l++) begin
      w_ne[l]   = (cnt_q[l] != 3'd0);
      w_push[l] = w_valid[l] && (cnt_q[l] != FULL_CNT);
      // A full FIFO drops the push even when it is popped at the same edge.
      w_ovf[l]  = w_valid[l] && (cnt_q[l] == FULL_CNT);
    end
    w_pop[0] = w_ne[0] && (!w_ne[1] || last_grant_q);
    w_pop[1] = w_ne[1] && (!w_ne[0] || !last_grant_q);
  end

  always_comb begin
    for (int l = 0; l < 2; l++) begin
      wptr_d[l] = wptr_q[l] + {1'b0, w_push[l]};
      rptr_d[l] = rptr_q[l] + {1'b0, w_pop[l]};
      cnt_d[l]  = cnt_q[l] + {2'b00, w_push[l]} - {2'b00, w_pop[l]};
    end
    data_out_d   = data_out_q;
    valid_out_d  = 1'b0;
    last_grant_d = last_grant_q;
    if (w_pop[0]) begin
      data_out_d   = mem_q[0][rptr_q[0]];
      valid_out_d  = 1'b1;
      last_grant_d = 1'b0;
    end else if (w_pop[1]) begin
      data_out_d   = mem_q[1][rptr_q[1]];
      valid_out_d  = 1'b1;
      last_grant_d = 1'b1;
    end
    err_d = err_q | (|w_ovf);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int l = 0; l < 2; l++) begin
        wptr_q[l] <= 2'd0;
        rptr_q[l] <= 2'd0;
        cnt_q[l]  <= 3'd0;
      end
      last_grant_q <= 1'b1;
      data_out_q   <= 4'h0;
      valid_out_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        wptr_q[l] <= wptr_d[l];
        rptr_q[l] <= rptr_d[l];
        cnt_q[l]  <= cnt_d[l];
      end
      last_grant_q <= last_grant_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
      err_q        <= err_d;
    end
  end

  // Storage has no reset. A write during reset lands in a slot that the
  // held-at-zero pointers and count never expose, so it is harmless.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (w_push[l]) begin
        mem_q[l][wptr_q[l]] <= w_din[l];
      end
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign full0     = (cnt_q[0] == FULL_CNT);
  assign full1     = (cnt_q[1] == FULL_CNT);
  assign err       = err_q;

endmodule
`default_nettype wire
